multiword_adder_ctrl: RTL and testbench
=======================================

Name: multiword_adder_ctrl

Overview:
Sequencer that performs WIDTH*WORDS-bit add/subtract by driving one external WIDTH-bit ADDER_FULL instance over WORDS consecutive cycles, LSB slice first, chaining carry through an internal register. Sits between an operand producer (valid/ready) and a result consumer (valid/ready). Lets the ALU reuse the narrow adder for wide operands without replicating it.

Parameters:
WIDTH, 4, bit width of the external adder slice
WORDS, 4, number of slices per operation (>=1); operand width = WIDTH*WORDS

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
IN_VALID  input  1  operand request valid
IN_READY  output  1  controller can accept a request
OP_A  input  WIDTH*WORDS  operand A
OP_B  input  WIDTH*WORDS  operand B
SUB  input  1  1 = A-B, 0 = A+B; sampled with operands
OUT_VALID  output  1  result valid
OUT_READY  input  1  consumer accepts result
RESULT  output  WIDTH*WORDS  sum/difference
C_OUT  output  1  carry out of MSB slice (raw; for SUB, 1 = no borrow)
OVERFLOW  output  1  signed overflow of the full-width operation
BUSY  output  1  high in RUN or DONE
ADD_A  output  WIDTH  slice A to adder
ADD_B  output  WIDTH  slice B to adder (inverted when SUB)
ADD_CIN  output  1  carry in to adder
ADD_SUM  input  WIDTH  adder sum (combinational from ADD_*)
ADD_COUT  input  1  adder carry out
ADD_OVF  input  1  adder signed overflow

Behaviour:
- Reset (async, RST=1): state IDLE; IN_READY=1 after reset deasserts (0 while RST high); OUT_VALID=0, RESULT=0, C_OUT=0, OVERFLOW=0, BUSY=0; slice counter=0; carry reg=0; operand regs=0.
- States IDLE, RUN, DONE.
- IDLE: IN_READY=1. IN_VALID=1 on rising edge -> latch OP_A, OP_B, SUB; carry reg <= SUB; counter <= 0; go RUN. No other state accepts requests.
- RUN (exactly WORDS cycles): in cycle i, ADD_A = A[i*WIDTH +: WIDTH], ADD_B = B slice XOR {WIDTH{SUB}}, ADD_CIN = carry reg. At edge: RESULT slice i <= ADD_SUM, carry reg <= ADD_COUT, counter++. On slice WORDS-1: C_OUT <= ADD_COUT, OVERFLOW <= ADD_OVF, go DONE.
- Outside RUN, ADD_A=0, ADD_B=0, ADD_CIN=0.
- Latency: accept edge to OUT_VALID=1 = WORDS+1 rising edges; OUT_VALID rises on the edge after the last slice.
- DONE: OUT_VALID=1; RESULT/C_OUT/OVERFLOW stable until handshake. OUT_VALID & OUT_READY at edge -> IDLE; OUT_VALID drops next cycle. A new request is accepted no earlier than the following IDLE cycle (no same-cycle turnaround).
- RESULT holds last value in IDLE; in RUN, upper slices not yet written keep prior contents (consumer must use OUT_VALID only).
- OP_A/OP_B/SUB/IN_VALID changes during RUN/DONE are ignored.
- WORDS=1: RUN lasts one cycle; behaviour otherwise identical.
- Counter width max(1, $clog2(WORDS)); no wrap except by return to IDLE.
- RST mid-RUN/DONE: operation discarded, all outputs to reset values immediately.
- BUSY = !IN_READY outside reset.

Test Plan:
- WIDTH=4, WORDS=4: ADD 0x1234+0x0FFF -> RESULT=0x2233, C_OUT=0, OVERFLOW=0, OUT_VALID exactly 5 edges after accept; ADD_* slices 4/F, 3/F, 2/F, 1/0 in order.
- ADD 0xFFFF+0x0001 -> RESULT=0x0000, C_OUT=1, OVERFLOW=0; ADD 0x7FFF+0x0001 -> RESULT=0x8000, C_OUT=0, OVERFLOW=1.
- SUB 0x0005-0x0007 -> first-slice ADD_CIN=1, ADD_B=0x8; RESULT=0xFFFE, C_OUT=0, OVERFLOW=0; SUB 0x8000-0x0001 -> RESULT=0x7FFF, C_OUT=1, OVERFLOW=1.
- Backpressure: OUT_READY=0 for 3 cycles in DONE -> OUT_VALID and RESULT stable, IN_READY=0; IN_VALID pulsed with new operands during RUN/DONE -> ignored, first result unchanged.
- Back-to-back: IN_VALID held high with two operand sets -> second accepted in the IDLE cycle after first OUT handshake; both results correct.
- RST asserted during RUN slice 2 -> OUT_VALID=0, RESULT=0, IN_READY=1 after release; next request completes normally.

Source files
------------

// File: rtl/multiword_adder_ctrl.sv
// Wide add/subtract sequencer: drives one external WIDTH-bit adder slice per cycle, LSB first.
// Latency: WORDS+1 rising edges from accept (inclusive) to OUT_VALID.
// Backpressure: result held in DONE until OUT_READY; no new request accepted until back in IDLE.
module multiword_adder_ctrl #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [WIDTH*WORDS-1:0] OP_A,
    input  logic [WIDTH*WORDS-1:0] OP_B,
    input  logic                   SUB,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [WIDTH*WORDS-1:0] RESULT,
    output logic                   C_OUT,
    output logic                   OVERFLOW,
    output logic                   BUSY,
    output logic [WIDTH-1:0]       ADD_A,
    output logic [WIDTH-1:0]       ADD_B,
    output logic                   ADD_CIN,
    input  logic [WIDTH-1:0]       ADD_SUM,
    input  logic                   ADD_COUT,
    input  logic                   ADD_OVF
);
    localparam int TW = WIDTH * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   a_reg;
    logic [TW-1:0]   b_reg;
    logic [TW-1:0]   res_reg;
    logic            sub_reg;
    logic            carry;
    logic            cout_reg;
    logic            ovf_reg;
    logic [WIDTH-1:0] slice_a;
    logic [WIDTH-1:0] slice_b;

    // Constant-index slice mux keeps the select free of variable part-selects.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (cnt == CW'(i)) begin
                slice_a = a_reg[i*WIDTH +: WIDTH];
                slice_b = b_reg[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ADD_A     = (state == RUN) ? slice_a : '0;
    assign ADD_B     = (state == RUN) ? (slice_b ^ {WIDTH{sub_reg}}) : '0;
    assign ADD_CIN   = (state == RUN) & carry;
    assign IN_READY  = (state == IDLE) & ~RST;
    assign BUSY      = (state != IDLE);
    assign OUT_VALID = (state == DONE);
    assign RESULT    = res_reg;
    assign C_OUT     = cout_reg;
    assign OVERFLOW  = ovf_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            sub_reg  <= 1'b0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        a_reg   <= OP_A;
                        b_reg   <= OP_B;
                        sub_reg <= SUB;
                        // Subtract is A + ~B + 1: the +1 enters as the first carry.
                        carry   <= SUB;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (cnt == CW'(i)) begin
                            res_reg[i*WIDTH +: WIDTH] <= ADD_SUM;
                        end
                    end
                    carry <= ADD_COUT;
                    if (cnt == LAST) begin
                        cout_reg <= ADD_COUT;
                        ovf_reg  <= ADD_OVF;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Bench for multiword_adder_ctrl with a behavioural 4-bit adder slice on the ADD_* port.
module tb_multiword_adder_ctrl;
    localparam int WIDTH = 4;
    localparam int WORDS = 4;
    localparam int TW    = WIDTH * WORDS;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [TW-1:0] OP_A = '0;
    logic [TW-1:0] OP_B = '0;
    logic          SUB = 1'b0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [TW-1:0] RESULT;
    logic          C_OUT;
    logic          OVERFLOW;
    logic          BUSY;
    logic [WIDTH-1:0] ADD_A;
    logic [WIDTH-1:0] ADD_B;
    logic          ADD_CIN;
    logic [WIDTH-1:0] ADD_SUM;
    logic          ADD_COUT;
    logic          ADD_OVF;

    multiword_adder_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OP_A(OP_A), .OP_B(OP_B), .SUB(SUB), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .RESULT(RESULT), .C_OUT(C_OUT), .OVERFLOW(OVERFLOW),
        .BUSY(BUSY), .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_CIN(ADD_CIN),
        .ADD_SUM(ADD_SUM), .ADD_COUT(ADD_COUT), .ADD_OVF(ADD_OVF)
    );

    always #5 CLK = ~CLK;

    // External adder slice
    always_comb begin
        {ADD_COUT, ADD_SUM} = {1'b0, ADD_A} + {1'b0, ADD_B} + {{WIDTH{1'b0}}, ADD_CIN};
        ADD_OVF = (ADD_A[WIDTH-1] == ADD_B[WIDTH-1]) && (ADD_SUM[WIDTH-1] != ADD_A[WIDTH-1]);
    end

    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          sub;
        logic [TW-1:0] res;
        logic          c;
        logic          o;
    } vec_t;

    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat;
    logic [WIDTH-1:0] cap_a[WORDS];
    logic [WIDTH-1:0] cap_b[WORDS];
    logic             cap_c[WORDS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!OUT_VALID && k < 30) begin
            @(negedge CLK);
            k++;
        end
        chk(name, 32'(OUT_VALID), 1);
    endtask

    // One full transaction; optional DONE backpressure and ignored request pokes.
    task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic s,
                          input logic [TW-1:0] er, input logic ec, input logic eo,
                          input int hold, input bit poke);
        int k;
        @(negedge CLK);
        OP_A = a; OP_B = b; SUB = s; IN_VALID = 1'b1;
        k = 0;
        while (!IN_READY && k < 20) begin
            @(negedge CLK);
            k++;
        end
        chk("in_ready_before_accept", 32'(IN_READY), 1);
        @(posedge CLK);
        lat = 1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        k = 0;
        while (!OUT_VALID && k < 20) begin
            if (k < WORDS) begin
                cap_a[k] = ADD_A;
                cap_b[k] = ADD_B;
                cap_c[k] = ADD_CIN;
            end
            if (poke) begin
                IN_VALID = (k == 1);
                OP_A = 16'hAAAA; OP_B = 16'h5555; SUB = ~s;
            end
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            k++;
        end
        chk("out_valid_rise", 32'(OUT_VALID), 1);
        chk("latency_edges", 32'(lat), 32'(WORDS + 1));
        for (int h = 0; h <= hold; h++) begin
            chk("result", 32'(RESULT), 32'(er));
            chk("c_out", 32'(C_OUT), 32'(ec));
            chk("overflow", 32'(OVERFLOW), 32'(eo));
            chk("in_ready_done", 32'(IN_READY), 0);
            chk("busy_done", 32'(BUSY), 1);
            if (poke) IN_VALID = (h == 1);
            if (h < hold) @(negedge CLK);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("out_valid_drop", 32'(OUT_VALID), 0);
        chk("in_ready_idle", 32'(IN_READY), 1);
    endtask

    initial begin
        vecs[0] = '{a: 16'h1234, b: 16'h0FFF, sub: 1'b0, res: 16'h2233, c: 1'b0, o: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, sub: 1'b0, res: 16'h0000, c: 1'b1, o: 1'b0};
        vecs[2] = '{a: 16'h7FFF, b: 16'h0001, sub: 1'b0, res: 16'h8000, c: 1'b0, o: 1'b1};
        vecs[3] = '{a: 16'h0005, b: 16'h0007, sub: 1'b1, res: 16'hFFFE, c: 1'b0, o: 1'b0};
        vecs[4] = '{a: 16'h8000, b: 16'h0001, sub: 1'b1, res: 16'h7FFF, c: 1'b1, o: 1'b1};
        vecs[5] = '{a: 16'h8000, b: 16'h8000, sub: 1'b0, res: 16'h0000, c: 1'b1, o: 1'b1};
        vecs[6] = '{a: 16'h1234, b: 16'h1234, sub: 1'b1, res: 16'h0000, c: 1'b1, o: 1'b0};

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_in_ready", 32'(IN_READY), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_out_valid", 32'(OUT_VALID), 0);
        chk("rst_result", 32'(RESULT), 0);
        chk("rst_c_out", 32'(C_OUT), 0);
        chk("rst_overflow", 32'(OVERFLOW), 0);
        chk("rst_add_a", 32'(ADD_A), 0);
        chk("rst_add_cin", 32'(ADD_CIN), 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_in_ready", 32'(IN_READY), 1);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].c, vecs[i].o,
                   (i == 0) ? 3 : 0, (i == 0));
            if (i == 0) begin
                chk("slice0_a", 32'(cap_a[0]), 'h4); chk("slice0_b", 32'(cap_b[0]), 'hF);
                chk("slice1_a", 32'(cap_a[1]), 'h3); chk("slice1_b", 32'(cap_b[1]), 'hF);
                chk("slice2_a", 32'(cap_a[2]), 'h2); chk("slice2_b", 32'(cap_b[2]), 'hF);
                chk("slice3_a", 32'(cap_a[3]), 'h1); chk("slice3_b", 32'(cap_b[3]), 'h0);
                chk("slice0_cin", 32'(cap_c[0]), 0);
            end
            if (i == 3) begin
                chk("sub_slice0_cin", 32'(cap_c[0]), 1);
                chk("sub_slice0_b", 32'(cap_b[0]), 'h8);
            end
        end

        // Back-to-back with IN_VALID and OUT_READY held high
        @(negedge CLK);
        OP_A = 16'h0102; OP_B = 16'h0304; SUB = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        OP_A = 16'h9000; OP_B = 16'h1001; SUB = 1'b1;
        wait_valid("b2b_first_valid");
        chk("b2b_first_result", 32'(RESULT), 'h0406);
        chk("b2b_first_c_out", 32'(C_OUT), 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("b2b_gap_out_valid", 32'(OUT_VALID), 0);
        chk("b2b_gap_in_ready", 32'(IN_READY), 1);
        @(posedge CLK);
        @(negedge CLK);
        chk("b2b_second_accepted", 32'(BUSY), 1);
        IN_VALID = 1'b0;
        wait_valid("b2b_second_valid");
        chk("b2b_second_result", 32'(RESULT), 'h7FFF);
        chk("b2b_second_c_out", 32'(C_OUT), 1);
        chk("b2b_second_overflow", 32'(OVERFLOW), 1);
        @(posedge CLK);
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("b2b_done_drop", 32'(OUT_VALID), 0);

        // Reset during RUN slice 2
        OP_A = 16'h1111; OP_B = 16'h2222; SUB = 1'b0; IN_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("mid_run_slice2_a", 32'(ADD_A), 'h1);
        chk("mid_run_partial", 32'(RESULT[7:0]), 'h33);
        RST = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(OUT_VALID), 0);
        chk("mid_rst_result", 32'(RESULT), 0);
        chk("mid_rst_in_ready", 32'(IN_READY), 0);
        chk("mid_rst_busy", 32'(BUSY), 0);
        chk("mid_rst_add_a", 32'(ADD_A), 0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("mid_rst_release_in_ready", 32'(IN_READY), 1);
        run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
